img_bit_loader: RTL
===================

Name: img_bit_loader

Overview:
- Sits between the UART receiver and the input image RAM feeding the CNN core.
- Takes each received byte (rx_data / rx_rdy) and unpacks it into single-bit writes to the 784-entry binarized-image RAM, LSB first.
- Pulses img_start once all 784 bits are stored, then holds off new bytes until the core reports the classification is done.

Parameters:
- IMG_BITS, 784, pixels per image (one bit each); must be a multiple of 8.
- ADDR_W, 10, width of the RAM address; must satisfy 2^ADDR_W >= IMG_BITS.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  received byte, valid when rx_rdy=1
- rx_rdy  in  1  one-cycle strobe, byte available
- core_done  in  1  one-cycle strobe from the core, inference complete (trmt)
- ram_we  out  1  input RAM write enable
- ram_addr  out  ADDR_W  input RAM write address
- ram_wdata  out  1  pixel bit to write
- img_start  out  1  one-cycle pulse, image complete, start core
- busy  out  1  high in SHIFT, START and WAIT
- overrun  out  1  sticky, a byte was dropped

Behaviour:
- Reset, synchronous, active-high, takes priority over all inputs:
  - Outputs ram_we=0, ram_addr=0, ram_wdata=0, img_start=0, busy=0, overrun=0.
  - Bit counter cleared to 0, hold buffer emptied, state = IDLE.
  - Reset mid-image discards every bit already written; the next image starts at address 0.
- Datapath:
  - 8-bit shift register plus a 1-entry hold buffer (hold_valid flag).
  - Bit counter bit_cnt, 0..IMG_BITS-1. ram_addr = bit_cnt, ram_wdata = shift[0].
- IDLE:
  - On rx_rdy: load the shift register with rx_data, set bit index k=0, go to SHIFT.
  - First write happens the cycle after the strobe.
- SHIFT:
  - Each cycle: ram_we=1, shift right by one, increment bit_cnt.
  - Exactly 8 write cycles per byte, bits 0..7 go to addresses 8n..8n+7.
  - rx_rdy while hold is empty: byte goes to hold.
  - rx_rdy while hold is full: byte dropped, overrun=1.
  - After write k=7:
    - If bit_cnt wrapped to IMG_BITS (last write was to address IMG_BITS-1): go to START; any held byte is discarded and overrun=1.
    - Else if hold is valid: load the shift register from hold and stay in SHIFT with no bubble cycle (16 contiguous ram_we cycles for two back-to-back bytes).
    - Else: go to IDLE.
  - rx_rdy on the same cycle as the k=7 write while hold is empty: the byte is captured and shifted out with no bubble.
- START:
  - img_start=1 for exactly one cycle, the cycle after the write to address IMG_BITS-1.
  - bit_cnt cleared to 0, then go to WAIT.
- WAIT:
  - ram_we=0. Any rx_rdy is dropped and sets overrun.
  - core_done goes to IDLE on the next cycle.
  - rx_rdy on the same cycle as core_done is dropped.
- Simultaneous events: core_done seen outside WAIT is ignored.
- overrun clears only on rst.
- busy=1 in SHIFT, START and WAIT.
- Latency: rx_rdy to first ram_we is 1 cycle; the last rx_rdy of an image (idle case) to img_start is 9 cycles.

Test Plan:
1. Reset, then rx_rdy with rx_data=8'hA5 in IDLE -> ram_we high for 8 cycles starting 1 cycle later, addresses 0..7, data 1,0,1,0,0,1,0,1; then IDLE with busy=0.
2. 98 bytes from a reference 784-bit image, spaced 50 cycles -> 784 writes matching the image bit-for-bit; img_start pulses once, 9 cycles after the 98th rx_rdy; busy=1; overrun=0.
3. Two rx_rdy on consecutive cycles (8'hFF, 8'h00) -> 16 contiguous ram_we cycles at addresses 0..15, data eight 1s then eight 0s; overrun=0.
4. Three rx_rdy on consecutive cycles -> third byte dropped, overrun=1; only 16 writes occur.
5. After a full image, rx_rdy in WAIT -> no write, overrun=1. core_done pulse -> IDLE; the next byte writes at address 0.
6. rst asserted after 40 bytes -> all outputs 0 next cycle. A new 98-byte image then writes addresses 0..783, and img_start fires exactly once.

Source files
------------

// File: rtl/img_bit_loader.sv
// rtl/img_bit_loader.sv - unpacks UART bytes LSB-first into single-bit image RAM writes
// Starts the core once a full image is stored and holds off new bytes until it finishes.
module img_bit_loader #(
    parameter int IMG_BITS = 784,
    parameter int ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_rdy,
    input  logic              core_done,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wdata,
    output logic              img_start,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_START,
        S_WAIT
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_BITS - 1);

    state_t            state_q, state_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        hold_q, hold_d;
    logic              hold_valid_q, hold_valid_d;
    logic [2:0]        k_q, k_d;
    logic [ADDR_W-1:0] bit_cnt_q, bit_cnt_d;
    logic              overrun_q, overrun_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            k_q          <= '0;
            bit_cnt_q    <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            k_q          <= k_d;
            bit_cnt_q    <= bit_cnt_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        k_d          = k_q;
        bit_cnt_d    = bit_cnt_q;
        overrun_d    = overrun_q;
        ram_we       = 1'b0;
        img_start    = 1'b0;
        busy         = 1'b1;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (rx_rdy) begin
                    shift_d = rx_data;
                    k_d     = 3'd0;
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                ram_we    = 1'b1;
                shift_d   = shift_q >> 1;
                k_d       = k_q + 3'd1;
                bit_cnt_d = bit_cnt_q + ADDR_W'(1);
                if (rx_rdy) begin
                    if (!hold_valid_q) begin
                        hold_d       = rx_data;
                        hold_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
                if (k_q == 3'd7) begin
                    if (bit_cnt_q == LAST_ADDR) begin
                        // Image complete: anything buffered belongs to no image and is lost.
                        state_d      = S_START;
                        bit_cnt_d    = '0;
                        hold_valid_d = 1'b0;
                        if (hold_valid_q || rx_rdy) begin
                            overrun_d = 1'b1;
                        end
                    end else if (hold_valid_q) begin
                        shift_d      = hold_q;
                        hold_valid_d = 1'b0;
                        k_d          = 3'd0;
                    end else if (rx_rdy) begin
                        // Byte arriving on the last bit goes straight to the shifter.
                        shift_d      = rx_data;
                        hold_valid_d = 1'b0;
                        k_d          = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_START: begin
                img_start = 1'b1;
                bit_cnt_d = '0;
                if (rx_rdy) begin
                    overrun_d = 1'b1;
                end
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (rx_rdy) begin
                    overrun_d = 1'b1;
                end
                if (core_done) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign ram_addr  = bit_cnt_q;
    assign ram_wdata = shift_q[0];
    assign overrun   = overrun_q;

endmodule
